// File: rtl/bcd_timer_2digit_pkg.sv
// Shared types and constants for the two-digit BCD timer.
package bcd_timer_2digit_pkg;
  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_ZERO = 4'd0;
  localparam bcd_t BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  function automatic logic bcd_valid(input bcd_t d);
    return d <= BCD_NINE;
  endfunction
endpackage

// File: rtl/bcd_timer_2digit_if.sv
// Control, preset and digit-output bundle between the timer and its neighbours.
interface bcd_timer_2digit_if;
  import bcd_timer_2digit_pkg::*;

  logic tick;
  logic start_pause;
  logic clear;
  logic dir;
  logic load;
  bcd_t load_tens;
  bcd_t load_ones;
  bcd_t tens;
  bcd_t ones;
  logic running;
  logic wrap;
  logic load_err;

  modport master (
    output tick, start_pause, clear, dir, load, load_tens, load_ones,
    input  tens, ones, running, wrap, load_err
  );

  modport slave (
    input  tick, start_pause, clear, dir, load, load_tens, load_ones,
    output tens, ones, running, wrap, load_err
  );
endinterface

// File: rtl/bcd_timer_2digit_bcd_digit.sv
// One up/down BCD digit; max_val is the roll-over point going up and the reload value going down.
module bcd_digit
  import bcd_timer_2digit_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_val,
  input  logic en,
  input  logic up,
  input  bcd_t max_val,
  output bcd_t value,
  output logic term,
  output logic carry
);

  assign term  = up ? (value >= max_val) : (value == BCD_ZERO);
  assign carry = en & term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= BCD_ZERO;
    end else if (clr) begin
      value <= BCD_ZERO;
    end else if (ld) begin
      value <= ld_val;
    end else if (en) begin
      if (term)
        value <= up ? BCD_ZERO : max_val;
      else if (up)
        value <= value + 4'd1;
      else
        value <= value - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_timer_2digit.sv
// Two-digit BCD up/down timer with start/pause/clear FSM and range-checked preset.
// Build option BCD_TIMER_STOP_AT_END_EN: stop in IDLE at the terminal value instead of wrapping.
//
// state | meaning
// IDLE  | stopped after reset/clear/end, count held, loads accepted
// RUN   | counting on tick, loads ignored
// PAUSE | halted by start_pause, count held, loads accepted
module bcd_timer_2digit
  import bcd_timer_2digit_pkg::*;
#(
  parameter int TOP_TENS = 5,
  parameter int TOP_ONES = 9
) (
  input logic              clk,
  input logic              rst_n,
  bcd_timer_2digit_if.slave bus
);

  localparam bcd_t TOP_T = bcd_t'(TOP_TENS);
  localparam bcd_t TOP_O = bcd_t'(TOP_ONES);

  state_t state_q, state_d;
  logic   running_q, wrap_q, load_err_q;
  logic   load_err_d, wrap_d;

  bcd_t   tens_v, ones_v;
  bcd_t   ones_max;
  logic   illegal, ld_ok, ld_act, step, end_hit, hold;
  logic   ones_en, ones_term, ones_carry, tens_term, tens_carry;
  logic   digit_clr, digit_ld;

  assign illegal = !bcd_valid(tens_v) || !bcd_valid(ones_v);
  assign ld_ok   = bcd_valid(bus.load_tens) && bcd_valid(bus.load_ones) &&
                   ({bus.load_tens, bus.load_ones} <= {TOP_T, TOP_O});
  assign ld_act  = bus.load && !bus.clear && (state_q != RUN);
  assign step    = bus.tick && !bus.clear && (state_q == RUN);

  // Ones rolls at TOP_ONES only on the top tens row (up) or reloads it from 00 (down).
  assign ones_max = bus.dir ? ((tens_v == BCD_ZERO) ? TOP_O : BCD_NINE)
                            : ((tens_v == TOP_T)    ? TOP_O : BCD_NINE);

  assign end_hit = step && !illegal && ones_term && tens_term;

`ifdef BCD_TIMER_STOP_AT_END_EN
  assign hold = end_hit;
`else
  assign hold = 1'b0;
`endif

  assign ones_en   = step && !illegal && !hold;
  assign digit_clr = bus.clear || (step && illegal);
  assign digit_ld  = ld_act && ld_ok;
  assign wrap_d    = hold || tens_carry;

  bcd_digit u_ones (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (digit_clr),
    .ld      (digit_ld),
    .ld_val  (bus.load_ones),
    .en      (ones_en),
    .up      (!bus.dir),
    .max_val (ones_max),
    .value   (ones_v),
    .term    (ones_term),
    .carry   (ones_carry)
  );

  bcd_digit u_tens (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (digit_clr),
    .ld      (digit_ld),
    .ld_val  (bus.load_tens),
    .en      (ones_carry),
    .up      (!bus.dir),
    .max_val (TOP_T),
    .value   (tens_v),
    .term    (tens_term),
    .carry   (tens_carry)
  );

  always_comb begin
    state_d    = state_q;
    load_err_d = 1'b0;
    if (bus.clear)
      state_d = IDLE;
    else if (ld_act)
      load_err_d = !ld_ok;
    else if (hold)
      state_d = IDLE;
    else if (bus.start_pause)
      state_d = (state_q == RUN) ? PAUSE : RUN;
    else if (state_q != IDLE && state_q != RUN && state_q != PAUSE)
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      running_q  <= (state_d == RUN);
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.tens     = tens_v;
  assign bus.ones     = ones_v;
  assign bus.running  = running_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_timer_2digit.sv
// Directed scenarios plus randomized traffic against a count-as-integer reference model.
module tb_bcd_timer_2digit;
  localparam int TOP_TENS = 5;
  localparam int TOP_ONES = 9;
  localparam int TOP      = TOP_TENS * 10 + TOP_ONES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  int   m_cnt;
  int   m_st;
  bit   m_wrap;
  bit   m_err;

  bcd_timer_2digit_if ifc();

  bcd_timer_2digit #(.TOP_TENS(TOP_TENS), .TOP_ONES(TOP_ONES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    ifc.tick = 0; ifc.start_pause = 0; ifc.clear = 0; ifc.dir = 0;
    ifc.load = 0; ifc.load_tens = 0; ifc.load_ones = 0;
  endtask

  task automatic apply(input bit t, input bit sp, input bit cl, input bit d, input bit ld,
                       input logic [3:0] lt, input logic [3:0] lo);
    @(negedge clk);
    ifc.tick = t; ifc.start_pause = sp; ifc.clear = cl; ifc.dir = d;
    ifc.load = ld; ifc.load_tens = lt; ifc.load_ones = lo;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Reference: count held as an integer 0..TOP; state 0 idle, 1 run, 2 pause.
  task automatic model_cycle(input bit t, input bit sp, input bit cl, input bit d, input bit ld,
                             input int lt, input int lo);
    bit done;
    done = 0;
    m_wrap = 0;
    m_err = 0;
    if (cl) begin
      m_cnt = 0;
      m_st = 0;
    end else if (ld && m_st != 1) begin
      if (lt <= 9 && lo <= 9 && lt * 10 + lo <= TOP) m_cnt = lt * 10 + lo;
      else m_err = 1;
    end else begin
      if (m_st == 1 && t) begin
        if ((!d && m_cnt == TOP) || (d && m_cnt == 0)) begin
          m_wrap = 1;
`ifdef BCD_TIMER_STOP_AT_END_EN
          m_st = 0;
          done = 1;
`else
          m_cnt = d ? TOP : 0;
`endif
        end else begin
          m_cnt = d ? m_cnt - 1 : m_cnt + 1;
        end
      end
      if (sp && !done) m_st = (m_st == 1) ? 2 : 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.running, ifc.wrap, ifc.load_err} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset: got %h%h run=%b wrap=%b err=%b, want 00 0 0 0",
               ifc.tens, ifc.ones, ifc.running, ifc.wrap, ifc.load_err);
    end
    repeat (3) apply(1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.running} !== 9'h0) begin
      miscompares++;
      $display("FAIL ticks_idle: got %h%h run=%b, want 00 run=0", ifc.tens, ifc.ones, ifc.running);
    end
  endtask

  task automatic test_count_up();
    do_reset();
    apply(0, 1, 0, 0, 0, 0, 0);
    vectors++;
    if (ifc.running !== 1'b1) begin
      miscompares++;
      $display("FAIL start_run: got running=%b, want 1", ifc.running);
    end
    for (int i = 1; i <= 12; i++) begin
      apply(1, 0, 0, 0, 0, 0, 0);
      if (i == 9 || i == 10) begin
        vectors++;
        if ({ifc.tens, ifc.ones} !== ((i == 9) ? 8'h09 : 8'h10)) begin
          miscompares++;
          $display("FAIL up_tick%0d: got %h%h, want %0d", i, ifc.tens, ifc.ones, i);
        end
      end
    end
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.running} !== {8'h12, 1'b1}) begin
      miscompares++;
      $display("FAIL up12: got %h%h run=%b, want 12 run=1", ifc.tens, ifc.ones, ifc.running);
    end
    apply(0, 1, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 4'd5, 4'd8);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.running, ifc.load_err} !== {8'h58, 2'b00}) begin
      miscompares++;
      $display("FAIL load58_pause: got %h%h run=%b err=%b, want 58 0 0",
               ifc.tens, ifc.ones, ifc.running, ifc.load_err);
    end
    apply(0, 1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.wrap} !== {8'h59, 1'b0}) begin
      miscompares++;
      $display("FAIL up59: got %h%h wrap=%b, want 59 wrap=0", ifc.tens, ifc.ones, ifc.wrap);
    end
    apply(1, 0, 0, 0, 0, 0, 0);
    vectors++;
`ifdef BCD_TIMER_STOP_AT_END_EN
    if ({ifc.tens, ifc.ones, ifc.wrap, ifc.running} !== {8'h59, 2'b10}) begin
      miscompares++;
      $display("FAIL up_end: got %h%h wrap=%b run=%b, want 59 wrap=1 run=0",
               ifc.tens, ifc.ones, ifc.wrap, ifc.running);
    end
`else
    if ({ifc.tens, ifc.ones, ifc.wrap, ifc.running} !== {8'h00, 2'b11}) begin
      miscompares++;
      $display("FAIL up_wrap: got %h%h wrap=%b run=%b, want 00 wrap=1 run=1",
               ifc.tens, ifc.ones, ifc.wrap, ifc.running);
    end
`endif
    apply(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (ifc.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_once: got wrap=%b, want 0", ifc.wrap);
    end
  endtask

  task automatic test_count_down();
    do_reset();
    apply(0, 1, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 1, 0, 0, 0);
    vectors++;
`ifdef BCD_TIMER_STOP_AT_END_EN
    if ({ifc.tens, ifc.ones, ifc.wrap, ifc.running} !== {8'h00, 2'b10}) begin
      miscompares++;
      $display("FAIL down_end: got %h%h wrap=%b run=%b, want 00 wrap=1 run=0",
               ifc.tens, ifc.ones, ifc.wrap, ifc.running);
    end
    apply(0, 0, 0, 1, 1, 4'd5, 4'd9);
    apply(0, 1, 0, 1, 0, 0, 0);
`else
    if ({ifc.tens, ifc.ones, ifc.wrap} !== {8'h59, 1'b1}) begin
      miscompares++;
      $display("FAIL down_wrap: got %h%h wrap=%b, want 59 wrap=1", ifc.tens, ifc.ones, ifc.wrap);
    end
`endif
    repeat (10) apply(1, 0, 0, 1, 0, 0, 0);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.wrap} !== {8'h49, 1'b0}) begin
      miscompares++;
      $display("FAIL down49: got %h%h wrap=%b, want 49 wrap=0", ifc.tens, ifc.ones, ifc.wrap);
    end
  endtask

  task automatic test_load_err();
    do_reset();
    apply(0, 0, 0, 0, 1, 4'd6, 4'd0);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.load_err} !== {8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL load60: got %h%h err=%b, want 00 err=1", ifc.tens, ifc.ones, ifc.load_err);
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (ifc.load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse: got err=%b, want 0", ifc.load_err);
    end
    apply(0, 0, 0, 0, 1, 4'd3, 4'hA);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.load_err} !== {8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL load3A: got %h%h err=%b, want 00 err=1", ifc.tens, ifc.ones, ifc.load_err);
    end
    apply(0, 0, 0, 0, 1, 4'd4, 4'd5);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.load_err, ifc.running} !== {8'h45, 2'b00}) begin
      miscompares++;
      $display("FAIL load45_idle: got %h%h err=%b run=%b, want 45 0 0",
               ifc.tens, ifc.ones, ifc.load_err, ifc.running);
    end
    apply(0, 1, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 4'd2, 4'd5);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.load_err, ifc.running} !== {8'h45, 2'b01}) begin
      miscompares++;
      $display("FAIL load_in_run: got %h%h err=%b run=%b, want 45 0 1",
               ifc.tens, ifc.ones, ifc.load_err, ifc.running);
    end
  endtask

  task automatic test_priority();
    do_reset();
    apply(0, 0, 0, 0, 1, 4'd3, 4'd7);
    apply(0, 1, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 0, 0, 0, 0);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.running, ifc.wrap} !== {8'h00, 2'b00}) begin
      miscompares++;
      $display("FAIL clear_wins: got %h%h run=%b wrap=%b, want 00 0 0",
               ifc.tens, ifc.ones, ifc.running, ifc.wrap);
    end
    apply(0, 0, 0, 0, 1, 4'd2, 4'd0);
    apply(0, 1, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 0);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.running} !== {8'h21, 1'b0}) begin
      miscompares++;
      $display("FAIL tick_sp_run: got %h%h run=%b, want 21 run=0", ifc.tens, ifc.ones, ifc.running);
    end
    apply(1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if ({ifc.tens, ifc.ones} !== 8'h21) begin
      miscompares++;
      $display("FAIL pause_hold: got %h%h, want 21", ifc.tens, ifc.ones);
    end
    apply(1, 1, 0, 0, 0, 0, 0);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.running} !== {8'h21, 1'b1}) begin
      miscompares++;
      $display("FAIL tick_sp_pause: got %h%h run=%b, want 21 run=1", ifc.tens, ifc.ones, ifc.running);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(0, 1, 0, 0, 0, 0, 0);
    repeat (5) apply(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #2;
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.running, ifc.wrap, ifc.load_err} !== 11'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h%h run=%b wrap=%b err=%b, want all 0",
               ifc.tens, ifc.ones, ifc.running, ifc.wrap, ifc.load_err);
    end
    @(negedge clk);
    rst_n = 1;
    apply(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if ({ifc.tens, ifc.ones, ifc.running, ifc.wrap, ifc.load_err} !== 11'h0) begin
      miscompares++;
      $display("FAIL post_release: got %h%h run=%b wrap=%b err=%b, want all 0",
               ifc.tens, ifc.ones, ifc.running, ifc.wrap, ifc.load_err);
    end
  endtask

  task automatic test_random();
    bit d;
    d = 0;
    do_reset();
    m_cnt = 0;
    m_st = 0;
    for (int i = 0; i < 4000; i++) begin
      bit t, sp, cl, ld;
      logic [3:0] lt, lo;
      t  = ($urandom_range(0, 2) != 0);
      sp = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 40) == 0) d = !d;
      lt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, TOP_TENS));
      lo = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      apply(t, sp, cl, d, ld, lt, lo);
      model_cycle(t, sp, cl, d, ld, int'(lt), int'(lo));
      vectors++;
      if ({ifc.tens, ifc.ones, ifc.running, ifc.wrap, ifc.load_err} !==
          {4'(m_cnt / 10), 4'(m_cnt % 10), (m_st == 1), m_wrap, m_err}) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h%h run=%b wrap=%b err=%b, want %0d run=%b wrap=%b err=%b",
                 i, ifc.tens, ifc.ones, ifc.running, ifc.wrap, ifc.load_err,
                 m_cnt, (m_st == 1), m_wrap, m_err);
      end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_count_up();
    test_count_down();
    test_load_err();
    test_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
